sync_mode_monitor: RTL and testbench



---
 rtl/sync_mode_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_sync_mode_monitor.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_mode_monitor.sv
// Per-frame sync measurement qualifier: lock/unlock FSM, held mode values, vsync watchdog.
// Optional SYNC_MODE_TOL_EN: accept +/- TOL clocks/line deviation instead of exact vcnt equality.
module sync_mode_monitor #(
  parameter int          LOCK_FRAMES   = 4,
  parameter int          UNLOCK_FRAMES = 2,
  parameter int          SAMPLE_DELAY  = 2,
  parameter logic [23:0] TIMEOUT       = 24'd4000000,
  parameter int          TOL           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [15:0] hcnt,
  input  logic [15:0] vcnt,
  input  logic [15:0] hpwcnt,
  input  logic [15:0] vpwcnt,
  output logic        locked,
  output logic        mode_change,
  output logic        no_signal,
  output logic [15:0] lock_hcnt,
  output logic [15:0] lock_vcnt,
  output logic [15:0] lock_hpwcnt,
  output logic [15:0] lock_vpwcnt,
  output logic [1:0]  state
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam int UW = $clog2(UNLOCK_FRAMES + 1);
  localparam int DW = $clog2(SAMPLE_DELAY + 1);
  localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_FRAMES);
  localparam logic [UW-1:0] UNLOCK_N = UW'(UNLOCK_FRAMES);
  localparam logic [DW-1:0] DLY_N    = DW'(SAMPLE_DELAY);
  localparam logic [DW-1:0] DLY_ONE  = DW'(1);
`ifdef SYNC_MODE_TOL_EN
  localparam logic [16:0] VTOL = 17'(TOL);
`else
  // Zero tolerance reduces the vcnt window compare to exact equality.
  localparam logic [16:0] VTOL = 17'(TOL * 0);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           vsync_q;
  logic [DW-1:0]  dly_q;
  logic [23:0]    wd_q;
  logic           no_signal_q;
  logic           mode_change_q, mode_change_d;
  logic [MW-1:0]  match_q, match_d, match_inc;
  logic [UW-1:0]  miss_q, miss_d, miss_inc;
  logic [15:0]    ref_h_q, ref_v_q, ref_hp_q, ref_vp_q;
  logic [15:0]    ref_h_d, ref_v_d, ref_hp_d, ref_vp_d;
  logic [15:0]    lk_h_q, lk_v_q, lk_hp_q, lk_vp_q;
  logic [15:0]    lk_h_d, lk_v_d, lk_hp_d, lk_vp_d;

  logic        rise, expire, strobe, valid, match;
  logic [16:0] vdiff;

  assign rise   = vsync & ~vsync_q;
  // A rise in the expiry cycle clears the watchdog instead, so expiry never coincides with it.
  assign expire = ~rise & (wd_q == TIMEOUT - 24'd1);
  assign strobe = ~rise & ~expire & (dly_q == DLY_ONE);

  assign valid = (hcnt != 16'd0) & (vcnt != 16'd0);
  assign vdiff = (vcnt >= ref_v_q) ? ({1'b0, vcnt} - {1'b0, ref_v_q})
                                   : ({1'b0, ref_v_q} - {1'b0, vcnt});
  assign match = (hcnt == ref_h_q) & (hpwcnt == ref_hp_q) & (vpwcnt == ref_vp_q) &
                 (vdiff <= VTOL);

  assign match_inc = (match_q == {MW{1'b1}}) ? match_q : match_q + 1'b1;
  assign miss_inc  = (miss_q == {UW{1'b1}}) ? miss_q : miss_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      dly_q       <= '0;
      wd_q        <= '0;
      no_signal_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (rise)
        wd_q <= '0;
      else if (wd_q != TIMEOUT)
        wd_q <= wd_q + 24'd1;
      if (rise)
        dly_q <= DLY_N;
      else if (expire)
        dly_q <= '0;
      else if (dly_q != '0)
        dly_q <= dly_q - 1'b1;
      if (expire)
        no_signal_q <= 1'b1;
      else if (rise)
        no_signal_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mode_change_d = 1'b0;
    match_d       = match_q;
    miss_d        = miss_q;
    ref_h_d       = ref_h_q;
    ref_v_d       = ref_v_q;
    ref_hp_d      = ref_hp_q;
    ref_vp_d      = ref_vp_q;
    lk_h_d        = lk_h_q;
    lk_v_d        = lk_v_q;
    lk_hp_d       = lk_hp_q;
    lk_vp_d       = lk_vp_q;
    if (expire) begin
      state_d       = S_IDLE;
      mode_change_d = (state_q == S_LOCKED);
    end else if (strobe) begin
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            {ref_h_d, ref_v_d, ref_hp_d, ref_vp_d} = {hcnt, vcnt, hpwcnt, vpwcnt};
            match_d = MW'(1);
            state_d = S_ACQ;
          end
        end
        S_ACQ: begin
          if (!valid) begin
            state_d = S_IDLE;
          end else if (match) begin
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d = S_LOCKED;
              {lk_h_d, lk_v_d, lk_hp_d, lk_vp_d} = {hcnt, vcnt, hpwcnt, vpwcnt};
              miss_d  = '0;
            end
          end else begin
            {ref_h_d, ref_v_d, ref_hp_d, ref_vp_d} = {hcnt, vcnt, hpwcnt, vpwcnt};
            match_d = MW'(1);
          end
        end
        S_LOCKED: begin
          if (valid && match) begin
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            if (miss_inc == UNLOCK_N) begin
              mode_change_d = 1'b1;
              if (valid) begin
                state_d = S_ACQ;
                {ref_h_d, ref_v_d, ref_hp_d, ref_vp_d} = {hcnt, vcnt, hpwcnt, vpwcnt};
                match_d = MW'(1);
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_change_q <= 1'b0;
      match_q       <= '0;
      miss_q        <= '0;
      ref_h_q       <= '0;
      ref_v_q       <= '0;
      ref_hp_q      <= '0;
      ref_vp_q      <= '0;
      lk_h_q        <= '0;
      lk_v_q        <= '0;
      lk_hp_q       <= '0;
      lk_vp_q       <= '0;
    end else begin
      mode_change_q <= mode_change_d;
      match_q       <= match_d;
      miss_q        <= miss_d;
      ref_h_q       <= ref_h_d;
      ref_v_q       <= ref_v_d;
      ref_hp_q      <= ref_hp_d;
      ref_vp_q      <= ref_vp_d;
      lk_h_q        <= lk_h_d;
      lk_v_q        <= lk_v_d;
      lk_hp_q       <= lk_hp_d;
      lk_vp_q       <= lk_vp_d;
    end
  end

  always_comb begin
    state       = state_q;
    locked      = (state_q == S_LOCKED);
    mode_change = mode_change_q;
    no_signal   = no_signal_q;
    lock_hcnt   = lk_h_q;
    lock_vcnt   = lk_v_q;
    lock_hpwcnt = lk_hp_q;
    lock_vpwcnt = lk_vp_q;
  end

endmodule

// File: tb/tb_sync_mode_monitor.sv
// Frame-level bench for sync_mode_monitor: directed scenarios plus randomized frames against a spec model.
module tb_sync_mode_monitor;

  localparam int          LOCK_FRAMES   = 4;
  localparam int          UNLOCK_FRAMES = 2;
  localparam int          SAMPLE_DELAY  = 2;
  localparam logic [23:0] TIMEOUT       = 24'd300;
  localparam int          TOL           = 4;
`ifdef SYNC_MODE_TOL_EN
  localparam int TOL_EFF = TOL;
`else
  localparam int TOL_EFF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic [15:0] hcnt = '0, vcnt = '0, hpwcnt = '0, vpwcnt = '0;
  logic        locked, mode_change, no_signal;
  logic [15:0] lock_hcnt, lock_vcnt, lock_hpwcnt, lock_vpwcnt;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  // Frame-level reference model
  int          m_state;
  int          m_match, m_miss, m_mc_total;
  logic [15:0] m_ref[4];
  logic [15:0] m_lk[4];

  int mc_pulses = 0, mc_wide = 0;
  bit mc_prev = 1'b0;

  sync_mode_monitor #(
    .LOCK_FRAMES(LOCK_FRAMES), .UNLOCK_FRAMES(UNLOCK_FRAMES), .SAMPLE_DELAY(SAMPLE_DELAY),
    .TIMEOUT(TIMEOUT), .TOL(TOL)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .hcnt(hcnt), .vcnt(vcnt), .hpwcnt(hpwcnt),
    .vpwcnt(vpwcnt), .locked(locked), .mode_change(mode_change), .no_signal(no_signal),
    .lock_hcnt(lock_hcnt), .lock_vcnt(lock_vcnt), .lock_hpwcnt(lock_hpwcnt),
    .lock_vpwcnt(lock_vpwcnt), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mode_change && !mc_prev) mc_pulses++;
    if (mode_change && mc_prev) mc_wide++;
    mc_prev = mode_change;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_state = 0; m_match = 0; m_miss = 0;
    for (int i = 0; i < 4; i++) begin
      m_ref[i] = '0;
      m_lk[i]  = '0;
    end
  endtask

  task automatic model_step(input logic [15:0] h, v, hp, vp, output bit mc);
    bit valid, same;
    int vdev;
    mc    = 1'b0;
    valid = (h != 0) && (v != 0);
    vdev  = (int'(v) > int'(m_ref[1])) ? int'(v) - int'(m_ref[1]) : int'(m_ref[1]) - int'(v);
    same  = (h == m_ref[0]) && (hp == m_ref[2]) && (vp == m_ref[3]) && (vdev <= TOL_EFF);
    case (m_state)
      0: if (valid) begin
        m_ref = '{h, v, hp, vp}; m_match = 1; m_state = 1;
      end
      1: if (!valid) m_state = 0;
      else if (same) begin
        m_match++;
        if (m_match == LOCK_FRAMES) begin
          m_state = 2; m_lk = '{h, v, hp, vp}; m_miss = 0;
        end
      end else begin
        m_ref = '{h, v, hp, vp}; m_match = 1;
      end
      default: if (valid && same) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == UNLOCK_FRAMES) begin
          mc = 1'b1;
          if (valid) begin
            m_state = 1; m_ref = '{h, v, hp, vp}; m_match = 1;
          end else m_state = 0;
        end
      end
    endcase
    if (mc) m_mc_total++;
  endtask

  // One vsync frame; checks the result SAMPLE_DELAY clocks after the rise.
  task automatic frame(input logic [15:0] h, v, hp, vp, input int len);
    bit exp_mc;
    @(negedge clk);
    vsync = 1'b1; hcnt = h; vcnt = v; hpwcnt = hp; vpwcnt = vp;
    @(posedge clk);
    repeat (SAMPLE_DELAY - 1) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (state !== 2'(m_state)) begin
      miscompares++;
      $display("FAIL pre_sample_state got %0d want %0d", state, m_state);
    end
    vectors++;
    if (no_signal !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_clears_no_signal got %b want 0", no_signal);
    end
    @(posedge clk);
    model_step(h, v, hp, vp, exp_mc);
    @(negedge clk);
    vectors++;
    if (state !== 2'(m_state)) begin
      miscompares++;
      $display("FAIL post_state got %0d want %0d", state, m_state);
    end
    vectors++;
    if (locked !== (m_state == 2)) begin
      miscompares++;
      $display("FAIL post_locked got %b want %b", locked, m_state == 2);
    end
    vectors++;
    if ({lock_hcnt, lock_vcnt, lock_hpwcnt, lock_vpwcnt} !== {m_lk[0], m_lk[1], m_lk[2], m_lk[3]}) begin
      miscompares++;
      $display("FAIL lock_values got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", lock_hcnt, lock_vcnt,
               lock_hpwcnt, lock_vpwcnt, m_lk[0], m_lk[1], m_lk[2], m_lk[3]);
    end
    vectors++;
    if (mode_change !== exp_mc) begin
      miscompares++;
      $display("FAIL mode_change got %b want %b", mode_change, exp_mc);
    end
    vsync = 1'b0;
    @(negedge clk);
    vectors++;
    if (mode_change !== 1'b0) begin
      miscompares++;
      $display("FAIL mode_change_width got %b want 0", mode_change);
    end
    repeat (len - SAMPLE_DELAY - 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    m_mc_total = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({state, locked, mode_change, no_signal} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 00000", {state, locked, mode_change, no_signal});
    end
    vectors++;
    if ({lock_hcnt, lock_vcnt, lock_hpwcnt, lock_vpwcnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_lock_values got %h want 0", {lock_hcnt, lock_vcnt, lock_hpwcnt, lock_vpwcnt});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({state, no_signal} !== 3'b0) begin
      miscompares++;
      $display("FAIL after_reset got %b want 000", {state, no_signal});
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < LOCK_FRAMES; i++) frame(16'd525, 16'd800, 16'd2, 16'd96, 20);
    vectors++;
    if ({locked, lock_hcnt, lock_vcnt, lock_hpwcnt, lock_vpwcnt} !== {1'b1, 16'd525, 16'd800, 16'd2, 16'd96}) begin
      miscompares++;
      $display("FAIL lock_525 got %b %0d/%0d/%0d/%0d want 1 525/800/2/96", locked, lock_hcnt,
               lock_vcnt, lock_hpwcnt, lock_vpwcnt);
    end
  endtask

  task automatic test_unlock();
    frame(16'd625, 16'd800, 16'd2, 16'd96, 18);
    frame(16'd525, 16'd800, 16'd2, 16'd96, 18);
    frame(16'd625, 16'd800, 16'd2, 16'd96, 18);
    frame(16'd625, 16'd800, 16'd2, 16'd96, 18);
    vectors++;
    if ({state, locked, lock_hcnt} !== {2'd1, 1'b0, 16'd525}) begin
      miscompares++;
      $display("FAIL unlock_625 got %0d %b %0d want 1 0 525", state, locked, lock_hcnt);
    end
  endtask

  task automatic test_reacquire();
    frame(16'd525, 16'd800, 16'd2, 16'd96, 16);
    frame(16'd525, 16'd800, 16'd2, 16'd96, 16);
    for (int i = 0; i < LOCK_FRAMES; i++) frame(16'd525, 16'd801, 16'd2, 16'd96, 16);
  endtask

  task automatic test_tolerance();
    for (int i = 0; i < LOCK_FRAMES; i++) frame(16'd525, 16'd800, 16'd2, 16'd96, 16);
    for (int i = 0; i < 6; i++) frame(16'd525, (i % 2 == 0) ? 16'd798 : 16'd802, 16'd2, 16'd96, 16);
    frame(16'd525, 16'd805, 16'd2, 16'd96, 16);
    frame(16'd525, 16'd805, 16'd2, 16'd96, 16);
  endtask

  task automatic test_watchdog();
    bit dummy;
    for (int i = 0; i < LOCK_FRAMES + 3; i++) frame(16'd525, 16'd800, 16'd2, 16'd96, 16);
    @(negedge clk);
    vsync = 1'b1;
    @(posedge clk);
    repeat (SAMPLE_DELAY) @(posedge clk);
    model_step(16'd525, 16'd800, 16'd2, 16'd96, dummy);
    @(negedge clk);
    vsync = 1'b0;
    repeat (int'(TIMEOUT) - 1 - SAMPLE_DELAY) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({no_signal, locked, mode_change} !== 3'b010) begin
      miscompares++;
      $display("FAIL wd_before_expiry got %b want 010", {no_signal, locked, mode_change});
    end
    @(posedge clk);
    @(negedge clk);
    m_mc_total += (m_state == 2) ? 1 : 0;
    m_state = 0;
    vectors++;
    if ({no_signal, locked, mode_change, state} !== 5'b10100) begin
      miscompares++;
      $display("FAIL wd_expiry got %b want 10100", {no_signal, locked, mode_change, state});
    end
    @(negedge clk);
    vectors++;
    if (mode_change !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_pulse_width got %b want 0", mode_change);
    end
    frame(16'd625, 16'd864, 16'd3, 16'd64, 20);
    repeat (int'(TIMEOUT)) @(negedge clk);
    m_state = 0;
    vectors++;
    if ({no_signal, state} !== 3'b100 || mc_pulses !== m_mc_total) begin
      miscompares++;
      $display("FAIL wd_from_acquire got %b pulses %0d want 100 pulses %0d", {no_signal, state},
               mc_pulses, m_mc_total);
    end
    frame(16'd625, 16'd864, 16'd3, 16'd64, 20);
  endtask

  task automatic test_random();
    int mode = 0;
    logic [15:0] h, v, hp, vp;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 99) < 15) mode = $urandom_range(0, 2);
      case (mode)
        0:       begin h = 16'd525;  v = 16'd800;  hp = 16'd2; vp = 16'd96; end
        1:       begin h = 16'd625;  v = 16'd864;  hp = 16'd3; vp = 16'd64; end
        default: begin h = 16'd1125; v = 16'd2200; hp = 16'd5; vp = 16'd44; end
      endcase
      if ($urandom_range(0, 99) < 20) v = 16'(int'(v) + int'($urandom_range(0, 12)) - 6);
      if ($urandom_range(0, 99) < 8) begin
        if ($urandom_range(0, 1) == 0) h = '0;
        else v = '0;
      end
      frame(h, v, hp, vp, $urandom_range(8, 40));
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < LOCK_FRAMES + 3; i++) frame(16'd525, 16'd800, 16'd2, 16'd96, 16);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_async_locked got %b want 1", locked);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({state, locked, mode_change, no_signal, lock_hcnt, lock_vcnt, lock_hpwcnt, lock_vpwcnt} !== 69'd0) begin
      miscompares++;
      $display("FAIL async_reset got state %0d locked %b lock_hcnt %0d want all 0", state, locked, lock_hcnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    frame(16'd525, 16'd800, 16'd2, 16'd96, 16);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_reacquire();
    test_tolerance();
    test_watchdog();
    test_random();
    test_async_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (mc_pulses !== m_mc_total || mc_wide !== 0) begin
      miscompares++;
      $display("FAIL mode_change_pulses got %0d (wide %0d) want %0d (wide 0)", mc_pulses, mc_wide, m_mc_total);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
